// File: rtl/sa_tile_sched_pkg.sv
// Shared types and constants for the systolic-array tile scheduler.
package sa_tile_sched_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_DEF     = 32;
  localparam int DRAIN_CYC = 2 * N_DEF - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Cycles for the last skewed operand to leave an N x N array.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sa_skew_buf.sv
// Triangular delay: lane i is delayed by i cycles; every stage clears to zero on reset.
module sa_skew_buf
  import sa_tile_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N*WIDTH-1:0] din,
  output logic [N*WIDTH-1:0] dout
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign dout[WIDTH-1:0] = din[WIDTH-1:0];
    end else begin : g_dly
      logic [WIDTH-1:0] sr [i];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int j = 0; j < i; j++) sr[j] <= '0;
        end else begin
          sr[0] <= din[i*WIDTH +: WIDTH];
          for (int j = 1; j < i; j++) sr[j] <= sr[j-1];
        end
      end

      assign dout[i*WIDTH +: WIDTH] = sr[i-1];
    end
  end

endmodule

// File: rtl/sa_tile_sched.sv
// Tile scheduler: streams k_len buffer rows into a skewed systolic array, then drains it.
// Optional run statistics (perf_cycles, perf_runs) are built when SA_SCHED_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one cycle clearing the PE accumulators
// FEED  | k_len buffer reads, addresses 0..k_len-1
// DRAIN | 2*N-1 cycles flushing zeros through the skew
// DONE  | one-cycle completion pulse
module sa_tile_sched
  import sa_tile_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF,
  parameter int KW    = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [KW-1:0]      rd_addr,
  input  logic [N*WIDTH-1:0] act_rd_data,
  input  logic [N*WIDTH-1:0] wt_rd_data,
  output logic [N*WIDTH-1:0] sa_activation,
  output logic [N*WIDTH-1:0] sa_weight,
  output logic               sa_control
`ifdef SA_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [15:0]        perf_runs
`endif
);

  localparam int DW = $clog2(2 * N);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(drain_cycles(N) - 1);

  state_t        state, state_nx;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] k_last;
  logic [DW-1:0] drain_cnt;
  logic          feed_v;
  logic [N*WIDTH-1:0] act_in, wt_in;

  assign k_last = k_reg - KW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    rd_en      = 1'b0;
    sa_control = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = (k_len == '0) ? DONE : CLEAR;
      CLEAR: begin
        busy     = 1'b1;
        state_nx = FEED;
      end
      FEED: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        sa_control = 1'b1;
        if (rd_addr == k_last) state_nx = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        sa_control = 1'b1;
        if (drain_cnt == '0) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address is cleared in CLEAR so it keeps its last value between runs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_reg     <= '0;
      rd_addr   <= '0;
      drain_cnt <= '0;
      feed_v    <= 1'b0;
    end else begin
      feed_v <= rd_en;
      if (state == IDLE && start) k_reg <= k_len;
      if (state == CLEAR) rd_addr <= '0;
      else if (state == FEED && rd_addr != k_last) rd_addr <= rd_addr + KW'(1);
      if (state == FEED) drain_cnt <= DRAIN_LOAD;
      else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
    end
  end

  // Read data is only meaningful the cycle after a strobe; otherwise zeros enter the skew.
  assign act_in = feed_v ? act_rd_data : '0;
  assign wt_in  = feed_v ? wt_rd_data  : '0;

  sa_skew_buf #(.WIDTH(WIDTH), .N(N)) u_skew_act (
    .clk  (clk),
    .rstn (rstn),
    .din  (act_in),
    .dout (sa_activation)
  );

  sa_skew_buf #(.WIDTH(WIDTH), .N(N)) u_skew_wt (
    .clk  (clk),
    .rstn (rstn),
    .din  (wt_in),
    .dout (sa_weight)
  );

`ifdef SA_SCHED_PERF_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cyc_cnt     <= '0;
      perf_cycles <= '0;
      perf_runs   <= '0;
    end else if (state == DONE) begin
      perf_cycles <= cyc_cnt;
      cyc_cnt     <= '0;
      perf_runs   <= perf_runs + 16'd1;
    end else if (busy) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_tile_sched.sv
// Directed-plus-random bench for sa_tile_sched against a cycle-offset reference model.
module tb_sa_tile_sched;
  import sa_tile_sched_pkg::*;

  localparam int WIDTH = WIDTH_DEF;
  localparam int N     = N_DEF;
  localparam int KW    = 10;
  localparam int TW    = N * WIDTH;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy, done, rd_en, sa_control;
  logic [KW-1:0] rd_addr;
  logic [TW-1:0] act_rd_data, wt_rd_data, sa_activation, sa_weight;
`ifdef SA_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_runs;
`endif

  sa_tile_sched #(.WIDTH(WIDTH), .N(N), .KW(KW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .k_len         (k_len),
    .busy          (busy),
    .done          (done),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .act_rd_data   (act_rd_data),
    .wt_rd_data    (wt_rd_data),
    .sa_activation (sa_activation),
    .sa_weight     (sa_weight),
    .sa_control    (sa_control)
`ifdef SA_SCHED_PERF_EN
    ,
    .perf_cycles   (perf_cycles),
    .perf_runs     (perf_runs)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int runs_exp = 0;
  logic [TW-1:0] act_mem [1024];
  logic [TW-1:0] wt_mem  [1024];

  function automatic logic [TW-1:0] rand_vec();
    logic [TW-1:0] v;
    for (int w = 0; w < TW / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one clock; the buffer model returns the row addressed during the previous cycle.
  task automatic step();
    logic          pre_en;
    logic [KW-1:0] pre_addr;
    pre_en   = rd_en;
    pre_addr = rd_addr;
    @(posedge clk);
    #1;
    act_rd_data = pre_en ? act_mem[pre_addr] : rand_vec();
    wt_rd_data  = pre_en ? wt_mem[pre_addr]  : rand_vec();
    #1;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, TW'(busy), '0);
    chk({tag, ".done"}, TW'(done), '0);
    chk({tag, ".rd_en"}, TW'(rd_en), '0);
    chk({tag, ".rd_addr"}, TW'(rd_addr), '0);
    chk({tag, ".sa_control"}, TW'(sa_control), '0);
    chk({tag, ".sa_activation"}, sa_activation, '0);
    chk({tag, ".sa_weight"}, sa_weight, '0);
`ifdef SA_SCHED_PERF_EN
    chk({tag, ".perf_cycles"}, TW'(perf_cycles), '0);
    chk({tag, ".perf_runs"}, TW'(perf_runs), '0);
`endif
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    start = 1'b0;
    step();
    step();
    check_zero("reset");
    rstn     = 1'b1;
    runs_exp = 0;
  endtask

  // Offsets d are counted from the start cycle (d=0): CLEAR at 1, reads at 2..k+1,
  // drain at k+2..k+64, done at k+65; a zero-depth run is done at d=1.
  task automatic run(input int k, input int restart_at, input int rst_at, input bit skew_pat);
    int total;
    int reads;
    int j;
    bit e_feed, e_drain;
    logic [TW-1:0] ea, ew;
    total = (k == 0) ? 1 : k + 2 * N + 1;
    for (int a = 0; a < k; a++) begin
      act_mem[a] = rand_vec();
      wt_mem[a]  = rand_vec();
    end
    if (skew_pat && k > 0) begin
      for (int i = 0; i < N; i++) begin
        act_mem[0][i*WIDTH +: WIDTH] = WIDTH'(i + 1);
        wt_mem[0][i*WIDTH +: WIDTH]  = WIDTH'(i + 1);
      end
    end
    start = 1'b1;
    k_len = KW'(k);
    step();
    reads = 0;
    for (int d = 1; d <= total + 1; d++) begin
      if (d == rst_at) begin
        rstn  = 1'b0;
        start = 1'b0;
        step();
        check_zero("mid_rst");
        rstn = 1'b1;
        return;
      end
      e_feed  = (d >= 2) && (d <= k + 1);
      e_drain = (k > 0) && (d >= k + 2) && (d <= k + 2 * N);
      chk("busy", TW'(busy), TW'((k > 0) && (d < total)));
      chk("done", TW'(done), TW'(d == total));
      chk("rd_en", TW'(rd_en), TW'(e_feed));
      if (e_feed)       chk("rd_addr", TW'(rd_addr), TW'(d - 2));
      else if (e_drain) chk("rd_addr_hold", TW'(rd_addr), TW'(k - 1));
      chk("sa_control", TW'(sa_control), TW'(e_feed || e_drain));
      ea = '0;
      ew = '0;
      for (int i = 0; i < N; i++) begin
        j = d - 3 - i;
        if (j >= 0 && j < k) begin
          ea[i*WIDTH +: WIDTH] = act_mem[j][i*WIDTH +: WIDTH];
          ew[i*WIDTH +: WIDTH] = wt_mem[j][i*WIDTH +: WIDTH];
        end
      end
      chk("sa_activation", sa_activation, ea);
      chk("sa_weight", sa_weight, ew);
      if (rd_en) reads++;
      start = (d == restart_at);
      k_len = (d == restart_at) ? KW'(9) : KW'($urandom());
      step();
    end
    start = 1'b0;
    chk("read_count", TW'(reads), TW'(k));
    runs_exp++;
`ifdef SA_SCHED_PERF_EN
    chk("perf_cycles", TW'(perf_cycles), TW'((k == 0) ? 0 : k + 2 * N));
    chk("perf_runs", TW'(perf_runs), TW'(runs_exp % 65536));
`endif
  endtask

  initial begin
    act_rd_data = rand_vec();
    wt_rd_data  = rand_vec();
    do_reset();
    run(4, 0, 0, 1'b0);
    run(8, 0, 0, 1'b1);
    run(0, 0, 0, 1'b0);
    run(5, 3, 0, 1'b0);
    run(3, 3 + 2 * N + 1, 0, 1'b0);
    run(6, 6 + 12, 0, 1'b0);
    run(2, 0, 0, 1'b0);
    do_reset();
    run(4, 0, 0, 1'b0);
    run(1, 0, 0, 1'b0);
    repeat (3) run($urandom_range(1, 24), 0, 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sa_tile_sched.md
SA_TILE_SCHED -- requirements
Module: sa_tile_sched

Interface
REQ-001 Parameter WIDTH, default 8, operand bit width per lane, SHALL be provided.
REQ-002 Parameter N, default 32, array dimension and lane count, SHALL be provided.
REQ-003 Parameter KW, default 10, bit width of k_len and of the buffer addresses, SHALL be provided.
REQ-004 Port clk  input  1  SHALL be the single clock; every flop is rising-edge.
REQ-005 Port rstn  input  1  SHALL be the synchronous, active-low reset.
REQ-006 Port start  input  1  SHALL request a tile run when the block is idle.
REQ-007 Port k_len  input  KW  SHALL give the reduction depth in cycles; it is sampled on an accepted start.
REQ-008 Port busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-009 Port done  output  1  SHALL be a one-cycle pulse at the end of a run.
REQ-010 Port rd_en  output  1  SHALL be the read strobe to both the activation and weight buffers.
REQ-011 Port rd_addr  output  KW  SHALL be the buffer read address.
REQ-012 Port act_rd_data  input  N*WIDTH  SHALL carry buffer data valid one cycle after rd_en.
REQ-013 Port wt_rd_data  input  N*WIDTH  SHALL carry buffer data valid one cycle after rd_en.
REQ-014 Port sa_activation  output  N*WIDTH  SHALL carry the skewed activations driven to the array.
REQ-015 Port sa_weight  output  N*WIDTH  SHALL carry the skewed weights driven to the array.
REQ-016 Port sa_control  output  1  SHALL be the array control: 1 = accumulate, 0 = clear PEs.

Function
REQ-017 The FSM SHALL have five states: IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-018 In IDLE, start=1 with k_len>0 SHALL move to CLEAR; start=1 with k_len=0 SHALL go straight to DONE.
REQ-019 CLEAR SHALL last 1 cycle with sa_control=0, then move to FEED.
REQ-020 FEED SHALL last k_len cycles.
  - rd_en=1 throughout; rd_addr counts 0..k_len-1.
  - sa_control=1.
REQ-021 DRAIN SHALL last exactly 2*N-1 cycles (63 at N=32), with rd_en=0, sa_control=1 and zero fed into the skew inputs.
REQ-022 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-023 Skew: lane i (LSB lane = 0) of sa_activation and sa_weight SHALL equal the lane-i buffer data delayed by i+1 cycles after rd_en.
  - Lane 0 therefore has 1-cycle latency; lane N-1 has N cycles.
REQ-024 Any lane not carrying valid skewed data SHALL output zero.
REQ-025 start SHALL be ignored while busy=1 or during DONE.
REQ-026 A k_len change during a run SHALL have no effect on the run.
REQ-027 The rd_addr counter SHALL not wrap.
  - k_len = 2^KW-1 is the maximum run.
  - rd_addr holds its last value when rd_en=0.

Reset
REQ-028 rstn=0 at a clock edge SHALL force the following, from any state including mid-FEED and mid-DRAIN, with no done pulse:
  - FSM = IDLE.
  - busy, done, rd_en = 0; rd_addr = 0.
  - sa_control = 0.
  - All skew registers = 0.
REQ-029 After reset release, the first start SHALL be accepted on the first edge with rstn=1.

Configuration
REQ-030 With macro SA_SCHED_PERF_EN defined, the block SHALL add:
  - Output perf_cycles (32 bits): cycles spent in CLEAR, FEED and DRAIN by the last completed run; updated in DONE, reset to 0.
  - Output perf_runs (16 bits): completed-run counter that wraps at 2^16.
REQ-031 Without SA_SCHED_PERF_EN, the ports and counters of REQ-030 SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package SHALL hold:
  - The state enum (IDLE, CLEAR, FEED, DRAIN, DONE).
  - Localparam DRAIN_CYC = 2*N-1.
  - The default WIDTH and N.
REQ-033 The triangular delay SHALL be one sub-module, sa_skew_buf (parameters WIDTH and N, zero-reset), instantiated once each for activations and weights.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Basic run: k_len=4, start -> busy next cycle; 1 CLEAR cycle; rd_addr 0,1,2,3; 63 DRAIN cycles; done pulses at cycle 69 after start; busy low with done.
  - Skew: lane i fed data i+1 at FEED cycle 0 -> sa_activation lane i is nonzero first exactly i+1 cycles after the first rd_en, lane 31 after 32 cycles.
  - Zero depth: k_len=0 -> done on the cycle after start; rd_en never asserted; sa_control stays 0.
  - Busy start: second start with k_len=9 issued mid-FEED of a k_len=5 run -> ignored; exactly 5 reads.
  - Reset mid-run: rstn=0 during DRAIN -> next cycle all outputs 0, no done pulse; a new start with k_len=2 completes normally.
  - With SA_SCHED_PERF_EN: two runs, k_len=4 then k_len=1 -> perf_cycles = 68 then 65; perf_runs = 2.
